// File: rtl/spi_cmd_frame_if.sv
// spi_cmd_frame_if: bundles the byte stream coming from the SPI slave
// receiver and the committed-command outputs going to the actuators.
//   master : the SPI-side/actuator-side environment (drives SSEL, bytes, clr_err)
//   slave  : spi_cmd_frame itself (drives cmd_out, cmd_update, cmd_valid, err,
//            frame_cnt)
interface spi_cmd_frame_if #(
  parameter int unsigned PAYLOAD_BYTES = 11
) ();
  logic                         SSEL;
  logic                         byte_valid;
  logic [7:0]                   byte_in;
  logic                         clr_err;
  logic [8*PAYLOAD_BYTES-1:0]   cmd_out;
  logic                         cmd_update;
  logic                         cmd_valid;
  logic [3:0]                   err;
  logic [7:0]                   frame_cnt;

  modport master (
    output SSEL, byte_valid, byte_in, clr_err,
    input  cmd_out, cmd_update, cmd_valid, err, frame_cnt
  );

  modport slave (
    input  SSEL, byte_valid, byte_in, clr_err,
    output cmd_out, cmd_update, cmd_valid, err, frame_cnt
  );
endinterface

// File: rtl/spi_cmd_frame.sv
// spi_cmd_frame: assembles one SSEL-delimited SPI transaction
// (header, PAYLOAD_BYTES payload bytes, checksum) into a shadow register and
// commits it atomically to cmd_out only when header, length and modulo-256
// checksum are all correct. Any malformed, short, long or stalled frame only
// sets a sticky error bit and leaves cmd_out untouched.
// Ports:
//   clk50M  : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : spi_cmd_frame_if.slave
//             in  SSEL (raw, async), byte_valid, byte_in[7:0], clr_err
//             out cmd_out[8*PAYLOAD_BYTES-1:0], cmd_update, cmd_valid,
//                 err[3:0] = {timeout, checksum, length, header}, frame_cnt[7:0]
module spi_cmd_frame #(
  parameter int unsigned PAYLOAD_BYTES = 11,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned TIMEOUT_CYC   = 5_000_000
) (
  input  logic              clk50M,
  input  logic              rst_n,
  spi_cmd_frame_if.slave    bus
);

  localparam int unsigned CW = 8 * PAYLOAD_BYTES;
  localparam int unsigned IW = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_CSUM     = 3'd3,
    S_TRAIL    = 3'd4,
    S_WAIT_END = 3'd5
  } state_t;

  // SSEL synchronizer plus registered edge strobes. The strobes are
  // registered so that the FSM acts on the 4th edge after the raw change.
  logic ssel_meta_q, ssel_sync_q, ssel_dly_q;
  logic ssel_rise_q, ssel_fall_q;
  logic ssel_rise_d, ssel_fall_d;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [CW-1:0]   cmd_q, cmd_d;
  logic            cmd_update_q, cmd_update_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [3:0]      err_q, err_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic [3:0]      err_set_s;
  logic            commit_s;
  logic            active_s;

  // Edge detect on the synchronized SSEL.
  always_comb begin
    ssel_rise_d = ssel_sync_q & ~ssel_dly_q;
    ssel_fall_d = ~ssel_sync_q & ssel_dly_q;
  end

  // SSEL synchronizer and edge strobe registers; idle level of SSEL is high.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      ssel_meta_q <= 1'b1;
      ssel_sync_q <= 1'b1;
      ssel_dly_q  <= 1'b1;
      ssel_rise_q <= 1'b0;
      ssel_fall_q <= 1'b0;
    end else begin
      ssel_meta_q <= bus.SSEL;
      ssel_sync_q <= ssel_meta_q;
      ssel_dly_q  <= ssel_sync_q;
      ssel_rise_q <= ssel_rise_d;
      ssel_fall_q <= ssel_fall_d;
    end
  end

  // Frame FSM: timeout first, then the byte of this cycle, then end-of-frame
  // evaluated on the post-byte state so a byte coinciding with the SSEL
  // rising strobe still belongs to the frame.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    shadow_d  = shadow_q;
    tmo_d     = tmo_q;
    err_set_s = 4'b0000;
    commit_s  = 1'b0;
    active_s  = (state_q == S_HDR) || (state_q == S_PAYLOAD) ||
                (state_q == S_CSUM) || (state_q == S_TRAIL);

    if (active_s) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    if (active_s && (tmo_q == TMO_LAST)) begin
      err_set_s[3] = 1'b1;
      state_d      = S_WAIT_END;
    end else if (bus.byte_valid) begin
      case (state_q)
        S_HDR: begin
          if (bus.byte_in == HEADER) begin
            sum_d   = bus.byte_in;
            state_d = S_PAYLOAD;
          end else begin
            err_set_s[0] = 1'b1;
            state_d      = S_WAIT_END;
          end
        end
        S_PAYLOAD: begin
          // Shifting in from the LSB leaves the first byte in the MSB slot.
          shadow_d = {shadow_q[CW-9:0], bus.byte_in};
          sum_d    = sum_q + bus.byte_in;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
        end
        S_CSUM: begin
          sum_d   = sum_q + bus.byte_in;
          state_d = S_TRAIL;
        end
        S_TRAIL: begin
          err_set_s[1] = 1'b1;
          state_d      = S_WAIT_END;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (ssel_rise_q) begin
      case (state_d)
        S_TRAIL: begin
          if (sum_d == 8'h00) begin
            commit_s = 1'b1;
          end else begin
            err_set_s[2] = 1'b1;
          end
          state_d = S_IDLE;
        end
        S_HDR, S_PAYLOAD, S_CSUM: begin
          err_set_s[1] = 1'b1;
          state_d      = S_IDLE;
        end
        S_WAIT_END: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if ((state_q == S_IDLE) && ssel_fall_q) begin
      state_d  = S_HDR;
      idx_d    = '0;
      sum_d    = 8'h00;
      shadow_d = '0;
      tmo_d    = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Output next-state: commit copies the whole shadow in one cycle; a new
  // error bit wins over a simultaneous clr_err.
  always_comb begin
    cmd_d        = cmd_q;
    cmd_update_d = 1'b0;
    cmd_valid_d  = cmd_valid_q;
    frame_cnt_d  = frame_cnt_q;
    if (commit_s) begin
      cmd_d        = shadow_q;
      cmd_update_d = 1'b1;
      cmd_valid_d  = 1'b1;
      frame_cnt_d  = frame_cnt_q + 8'd1;
    end else begin
      cmd_d = cmd_q;
    end
    if (bus.clr_err) begin
      err_d = err_set_s;
    end else begin
      err_d = err_q | err_set_s;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      sum_q        <= 8'h00;
      shadow_q     <= '0;
      tmo_q        <= '0;
      cmd_q        <= '0;
      cmd_update_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      err_q        <= 4'b0000;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      shadow_q     <= shadow_d;
      tmo_q        <= tmo_d;
      cmd_q        <= cmd_d;
      cmd_update_q <= cmd_update_d;
      cmd_valid_q  <= cmd_valid_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.cmd_out    = cmd_q;
  assign bus.cmd_update = cmd_update_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.err        = err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_spi_cmd_frame.sv
// tb_spi_cmd_frame: scenario tasks drive SPI frames through the interface;
// every frame that should commit pushes its expected command word and frame
// count to a scoreboard queue, and a negedge monitor pops and compares on
// each cmd_update pulse. Scenario tasks check err/cmd_out/latency inline.
module tb_spi_cmd_frame;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [87:0] cmd;
    logic [7:0]  cnt;
  } exp_t;

  logic clk50M = 1'b0;
  logic rst_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  exp_t        exp_q [$];
  logic [7:0]  exp_cnt   = 8'd0;
  logic [87:0] model_cmd = '0;

  spi_cmd_frame_if #(.PAYLOAD_BYTES(11)) bus ();

  spi_cmd_frame #(
    .PAYLOAD_BYTES(11),
    .HEADER       (8'hA5),
    .TIMEOUT_CYC  (100)
  ) dut (
    .clk50M(clk50M),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk50M = ~clk50M;

  // Scoreboard monitor: every cmd_update must match the oldest expectation.
  always @(negedge clk50M) begin
    exp_t e;
    if (rst_n && (bus.cmd_update === 1'b1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit cmd_out=%h frame_cnt=%0d expected no commit", bus.cmd_out, bus.frame_cnt);
      end else begin
        e = exp_q.pop_front();
        if ((bus.cmd_out !== e.cmd) || (bus.frame_cnt !== e.cnt)) begin
          bad++;
          $display("FAIL commit_data cmd_out=%h cnt=%0d expected cmd_out=%h cnt=%0d", bus.cmd_out, bus.frame_cnt, e.cmd, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic ssel_low();
    bus.SSEL = 1'b0;
    repeat (5) tick();
  endtask

  task automatic ssel_high();
    bus.SSEL = 1'b1;
    repeat (6) tick();
  endtask

  task automatic send_bytes(input bq_t bq);
    foreach (bq[i]) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = bq[i];
      tick();
    end
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
  endtask

  // Header + payload bytes, and the checksum byte that zeroes the sum.
  task automatic build(input logic [87:0] p, output bq_t bq, output logic [7:0] cs);
    logic [7:0] s;
    bq = {};
    bq.push_back(8'hA5);
    s = 8'hA5;
    for (int i = 0; i < 11; i++) begin
      bq.push_back(p[87-8*i -: 8]);
      s = s + p[87-8*i -: 8];
    end
    cs = 8'h00 - s;
  endtask

  task automatic expect_commit(input logic [87:0] p);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({p, exp_cnt});
    model_cmd = p;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    tick();
  endtask

  task automatic send_valid(input logic [87:0] p);
    bq_t bq;
    logic [7:0] cs;
    build(p, bq, cs);
    bq.push_back(cs);
    expect_commit(p);
    ssel_low();
    send_bytes(bq);
    ssel_high();
  endtask

  task automatic check_err(input string name, input logic [3:0] req);
    total++;
    if (bus.err !== req) begin
      bad++;
      $display("FAIL %s err=%b expected %b", name, bus.err, req);
    end
  endtask

  task automatic check_cmd_kept(input string name);
    total++;
    if ((bus.cmd_out !== model_cmd) || (exp_q.size() != 0)) begin
      bad++;
      $display("FAIL %s cmd_out=%h pending=%0d expected cmd_out=%h pending=0", name, bus.cmd_out, exp_q.size(), model_cmd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ((bus.cmd_out !== 88'd0) || (bus.cmd_update !== 1'b0) || (bus.cmd_valid !== 1'b0) ||
        (bus.err !== 4'd0) || (bus.frame_cnt !== 8'd0)) begin
      bad++;
      $display("FAIL reset_values cmd=%h upd=%b valid=%b err=%b cnt=%0d expected all zero",
               bus.cmd_out, bus.cmd_update, bus.cmd_valid, bus.err, bus.frame_cnt);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_valid_zero();
    send_valid(88'd0);
    check_cmd_kept("zero_frame_commit");
    check_err("zero_frame_err", 4'b0000);
    total++;
    if ((bus.cmd_valid !== 1'b1) || (bus.frame_cnt !== 8'd1)) begin
      bad++;
      $display("FAIL zero_frame_status valid=%b cnt=%0d expected valid=1 cnt=1", bus.cmd_valid, bus.frame_cnt);
    end
  endtask

  task automatic test_payload_latency();
    bq_t bq;
    logic [7:0] cs;
    logic [87:0] p;
    p = 88'h0102030405060708090A0B;
    build(p, bq, cs);
    // 01..0B sums to 0x42; A5 + 42 + 19 = 0x100.
    total++;
    if (cs !== 8'h19) begin
      bad++;
      $display("FAIL csum_model cs=%h expected 19", cs);
    end
    bq.push_back(cs);
    expect_commit(p);
    ssel_low();
    send_bytes(bq);
    bus.SSEL = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      total++;
      if (bus.cmd_update !== ((e == 4) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL commit_latency edge=%0d cmd_update=%b expected %b", e, bus.cmd_update, (e == 4));
      end
    end
    total++;
    if ((bus.cmd_out[87:80] !== 8'h01) || (bus.cmd_out[7:0] !== 8'h0B)) begin
      bad++;
      $display("FAIL payload_order msb=%h lsb=%h expected 01 0b", bus.cmd_out[87:80], bus.cmd_out[7:0]);
    end
    repeat (3) tick();
  endtask

  task automatic test_bad_csum();
    bq_t bq;
    logic [7:0] cs;
    build(88'h0102030405060708090A0B, bq, cs);
    bq.push_back(cs + 8'd1);
    ssel_low();
    send_bytes(bq);
    ssel_high();
    check_err("bad_csum_err", 4'b0100);
    check_cmd_kept("bad_csum_cmd");
    pulse_clr();
    check_err("bad_csum_clr", 4'b0000);
  endtask

  task automatic test_length();
    bq_t bq;
    logic [7:0] cs;
    build(88'hDEADBEEF00112233445566, bq, cs);
    bq = bq[0:7];
    ssel_low();
    send_bytes(bq);
    ssel_high();
    check_err("short_err", 4'b0010);
    check_cmd_kept("short_cmd");
    pulse_clr();
    check_err("short_clr", 4'b0000);
    // Header error leaves err[0]; clr_err coinciding with a new length error.
    ssel_low();
    send_bytes('{8'h5A, 8'h01});
    ssel_high();
    check_err("pre_clr_hdr", 4'b0001);
    ssel_low();
    send_bytes(bq);
    bus.SSEL = 1'b1;
    repeat (3) tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    repeat (3) tick();
    check_err("clr_vs_new_err", 4'b0010);
    pulse_clr();
    build(88'hDEADBEEF00112233445566, bq, cs);
    bq.push_back(cs);
    bq.push_back(8'h00);
    bq.push_back(8'h00);
    ssel_low();
    send_bytes(bq);
    ssel_high();
    check_err("long_err", 4'b0010);
    check_cmd_kept("long_cmd");
    pulse_clr();
  endtask

  task automatic test_header();
    bq_t bq;
    logic [7:0] cs;
    logic [87:0] p;
    p = 88'h112233445566778899AABB;
    build(p, bq, cs);
    bq[0] = 8'h5A;
    bq.push_back(cs);
    ssel_low();
    send_bytes(bq);
    ssel_high();
    check_err("header_err", 4'b0001);
    check_cmd_kept("header_cmd");
    pulse_clr();
    send_valid(p);
    check_cmd_kept("after_header_commit");
    check_err("after_header_err", 4'b0000);
  endtask

  task automatic test_back_to_back();
    bq_t bq;
    logic [7:0] cs;
    logic [87:0] p;
    p = {$urandom, $urandom, 24'($urandom)};
    build(p, bq, cs);
    expect_commit(p);
    ssel_low();
    send_bytes(bq);
    // Checksum byte lands exactly in the SSEL rising-edge detect cycle.
    bus.SSEL = 1'b1;
    repeat (3) tick();
    bus.byte_valid = 1'b1;
    bus.byte_in    = cs;
    tick();
    bus.byte_valid = 1'b0;
    repeat (4) tick();
    check_cmd_kept("late_csum_commit");
    check_err("late_csum_err", 4'b0000);
  endtask

  task automatic test_timeout();
    ssel_low();
    send_bytes('{8'hA5, 8'h01, 8'h02});
    repeat (120) tick();
    check_err("timeout_err", 4'b1000);
    ssel_high();
    check_err("timeout_after_end", 4'b1000);
    check_cmd_kept("timeout_cmd");
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    ssel_low();
    send_bytes('{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40});
    rst_n = 1'b0;
    #2;
    total++;
    if ((bus.cmd_out !== 88'd0) || (bus.cmd_valid !== 1'b0) || (bus.err !== 4'd0) ||
        (bus.frame_cnt !== 8'd0) || (bus.cmd_update !== 1'b0)) begin
      bad++;
      $display("FAIL async_reset cmd=%h valid=%b err=%b cnt=%0d expected all zero",
               bus.cmd_out, bus.cmd_valid, bus.err, bus.frame_cnt);
    end
    exp_cnt   = 8'd0;
    model_cmd = '0;
    bus.SSEL  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send_valid(88'hCAFE0000000000000000FF);
    check_cmd_kept("post_reset_commit");
    total++;
    if (bus.frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL post_reset_cnt cnt=%0d expected 1", bus.frame_cnt);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    exp_cnt   = 8'd0;
    model_cmd = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int n = 0; n < 256; n++) begin
      send_valid({$urandom, $urandom, 24'($urandom)});
    end
    check_cmd_kept("wrap_last_cmd");
    total++;
    if ((bus.frame_cnt !== 8'd0) || (bus.cmd_valid !== 1'b1)) begin
      bad++;
      $display("FAIL frame_cnt_wrap cnt=%0d valid=%b expected cnt=0 valid=1", bus.frame_cnt, bus.cmd_valid);
    end
  endtask

  initial begin
    bus.SSEL       = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.clr_err    = 1'b0;
    test_reset();
    test_valid_zero();
    test_payload_latency();
    test_bad_csum();
    test_length();
    test_header();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_commits pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
